// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding and
//   the signed-overflow helper used when the last result bit is produced.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Two's-complement subtraction overflows when the operands differ in sign
    // and the result sign differs from the minuend sign.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
//   Ports:
//     x    in  1  minuend bit
//     y    in  1  subtrahend bit
//     bin  in  1  borrow in
//     d    out 1  difference bit
//     bout out 1  borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x outright, or when x==y and a borrow is pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor, diff = a - b, one bit per clock
//   through a single full-subtractor cell and a borrow flop.
//   Ports:
//     clk        in   1      clock, posedge
//     rst        in   1      asynchronous active-high reset
//     in_valid   in   1      operands valid
//     in_ready   out  1      operands accepted (IDLE only)
//     a, b       in   WIDTH  minuend, subtrahend
//     out_valid  out  1      result valid (DONE only)
//     out_ready  in   1      consumer accepts result
//     diff       out  WIDTH  (a - b) mod 2^WIDTH
//     borrow     out  1      a < b unsigned
//     ovf        out  1      signed overflow
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] d_sh_q;
    logic [WIDTH-1:0] d_sh_d;
    logic             bor_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             fs_d_s;
    logic             fs_bout_s;

    full_subtractor u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (bor_q),
        .d    (fs_d_s),
        .bout (fs_bout_s)
    );

    // New difference bit enters from the MSB end so the LSB lands at bit 0
    // after WIDTH shifts.
    assign d_sh_d = {fs_d_s, d_sh_q[WIDTH-1:1]};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_SHIFT;
                else          state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                   state_d = ST_SHIFT;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
                else           state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode, from the next state so the registered flags track
    // the state register exactly.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            ST_IDLE:  in_ready_d  = 1'b1;
            ST_DONE:  out_valid_d = 1'b1;
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand/difference shift registers, borrow flop, counter and result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            bor_q    <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        bor_q   <= 1'b0;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    d_sh_q <= d_sh_d;
                    bor_q  <= fs_bout_s;
                    if (cnt_q == CNT_LAST) begin
                        // Last bit: publish the result; outputs hold it until
                        // the next operation completes.
                        cnt_q    <= '0;
                        diff_q   <= d_sh_d;
                        borrow_q <= fs_bout_s;
                        ovf_q    <= signed_ovf(a_msb_q, b_msb_q, fs_d_s);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=4). A transaction-level
//   model predicts handshake timing and results from plain arithmetic; a
//   negedge compare process checks every output each cycle.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int n_vec = 0;
    int n_mis = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = waiting for operands, 1 = computing, 2 = result offered.
    int           m_phase = 0;
    int           m_edges = 0;
    logic [W-1:0] m_pa = '0;
    logic [W-1:0] m_pb = '0;
    logic [W-1:0] m_diff = '0;
    logic         m_bor = 1'b0;
    logic         m_ovf = 1'b0;

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = (int'(x) - int'(y) + 16) % 16;
        return r[W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int r;
        sx = (int'(x) >= 8) ? int'(x) - 16 : int'(x);
        sy = (int'(y) >= 8) ? int'(y) - 16 : int'(y);
        r  = sx - sy;
        return (r < -8) || (r > 7);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_edges <= 0;
            m_diff  <= '0;
            m_bor   <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_edges <= 0;
                    m_pa    <= a;
                    m_pb    <= b;
                end
                1: begin
                    m_edges <= m_edges + 1;
                    if (m_edges + 1 == W) begin
                        m_phase <= 2;
                        m_diff  <= ref_diff(m_pa, m_pb);
                        m_bor   <= (m_pa < m_pb);
                        m_ovf   <= ref_ovf(m_pa, m_pb);
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            if (in_ready !== (m_phase == 0) || out_valid !== (m_phase == 2) ||
                diff !== m_diff || borrow !== m_bor || ovf !== m_ovf) begin
                n_mis++;
                $display("FAIL cycle t=%0t: got ir=%b ov=%b diff=%0d bor=%b ovf=%b, want ir=%b ov=%b diff=%0d bor=%b ovf=%b",
                         $time, in_ready, out_valid, diff, borrow, ovf,
                         (m_phase == 0), (m_phase == 2), m_diff, m_bor, m_ovf);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_mis++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Runs one operation; returns at a negedge with out_ready just raised.
    // Optionally offers other operands while the result is held.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input int hold, input bit iv_in_hold);
        int t;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            out_ready = 1'b0;
            t++;
        end
        out_ready = 1'b0;
        if (!in_ready) check("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            if (iv_in_hold) begin
                a = 4'd15;
                b = 4'd15;
                in_valid = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [4:0] s;
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_diff", int'(diff), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(4'd0, 4'd0, 0, 1'b0);
        check("0-0 diff", int'(diff), 0);
        check("0-0 ovf", int'(ovf), 0);
        do_op(4'd3, 4'd1, 1, 1'b0);
        check("3-1 diff", int'(diff), 2);
        check("3-1 borrow", int'(borrow), 0);
        do_op(4'd5, 4'd4, 0, 1'b0);
        check("5-4 diff", int'(diff), 1);
        do_op(4'd9, 4'd3, 2, 1'b0);
        check("9-3 diff", int'(diff), 6);
        check("9-3 borrow", int'(borrow), 0);
        check("9-3 ovf", int'(ovf), 1);
        do_op(4'd1, 4'd15, 0, 1'b0);
        check("1-15 diff", int'(diff), 2);
        check("1-15 borrow", int'(borrow), 1);
        check("1-15 ovf", int'(ovf), 0);
        do_op(4'd0, 4'd1, 0, 1'b0);
        check("0-1 diff", int'(diff), 15);
        check("0-1 borrow", int'(borrow), 1);

        // Hold: result offered 5 cycles with new operands presented and ignored.
        do_op(4'd9, 4'd3, 5, 1'b1);
        check("hold diff", int'(diff), 6);
        check("hold in_ready", int'(in_ready), 0);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

        // Reset in the middle of a computation.
        a = 4'd7;
        b = 4'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst diff", int'(diff), 0);
        check("midrst in_ready", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst no result", int'(out_valid), 0);

        // Inverse check: feed adder results back and recover the addend.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                s = 5'(x + y);
                do_op(s[3:0], 4'(y), int'($urandom_range(0, 2)), 1'b0);
                check("inv diff", int'(diff), x);
                check("inv borrow", int'(borrow), int'(s[4]));
            end
        end

        // Random operands and result back-pressure.
        for (int k = 0; k < 100; k++) begin
            do_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom));
        end
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
